branch_seq_ctrl: RTL and testbench
==================================

# branch_seq_ctrl

Multicycle sequencer for the branch datapath. It fetches each instruction over a request/acknowledge handshake and decodes B, CBZ and CBNZ. It sign-extends the branch offset, reads the test register, and updates the 64-bit PC. It sits between instruction memory, the register file read port and the PC, and owns the PC register.

## Interface
Parameters:
- RESET_PC, 64'h0: PC value loaded on reset.
- HALT_WORD, 32'hD4400000: instruction encoding that stops sequencing.

Ports:
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: begins sequencing from the current PC when in IDLE.
- if_req, output, 1: instruction fetch request.
- if_addr, output, 64: fetch address; equals pc.
- if_ack, input, 1: fetch acknowledge; if_data is valid in the same cycle.
- if_data, input, 32: fetched instruction.
- rf_addr, output, 5: register file read address; equals instr[4:0].
- rf_data, input, 64: combinational read data for rf_addr.
- pc, output, 64: current PC.
- retire, output, 1: one-cycle pulse when the PC is updated.
- br_taken, output, 1: one-cycle pulse, coincident with retire, when a branch redirects the PC.
- busy, output, 1: high in every state except IDLE and HALTED.
- halted, output, 1: high in HALTED.

## Operation
- States: IDLE, FETCH, DECODE, READ, EXEC, UPDATE, HALTED.
- IDLE:
  - start=1 goes to FETCH.
  - start=0 stays in IDLE.
- FETCH:
  - if_req=1, if_addr=pc.
  - On if_ack=1, latch if_data into instr.
  - If if_data==HALT_WORD, go to HALTED; otherwise go to DECODE.
  - Without if_ack, stay in FETCH and hold if_req.
- DECODE: classify instr.
  - B: instr[31:26]==6'b000101; imm = sign-extend instr[25:0] to 64 bits.
  - CBZ: instr[31:24]==8'b10110100; imm = sign-extend instr[23:5].
  - CBNZ: instr[31:24]==8'b10110101; imm = sign-extend instr[23:5].
  - Anything else is non-branch.
  - CBZ and CBNZ go to READ; B and non-branch go to EXEC.
- READ: latch rf_data into opnd, then go to EXEC.
  - If instr[4:0]==5'd31, opnd=0 (XZR) regardless of rf_data.
- EXEC: compute the next PC, then go to UPDATE.
  - target = pc + (imm << 2), mod 2^64; wrap-around is silent.
  - B: next = target.
  - CBZ: next = target if opnd==0, else pc+4.
  - CBNZ: next = target if opnd!=0, else pc+4.
  - Non-branch: next = pc+4.
- UPDATE:
  - pc <= next; pulse retire.
  - br_taken=1 iff next was selected from target. A taken branch whose offset is zero still counts as taken.
  - Go to FETCH.
- HALTED:
  - pc unchanged, retire never pulses.
  - Exit only via reset; start is ignored.
- Reset values: pc=RESET_PC, state=IDLE, if_req=0, retire=0, br_taken=0, busy=0, halted=0, instr=0, opnd=0.
- Reset asserted mid-instruction returns to IDLE immediately and discards the partial instruction; pc returns to RESET_PC.
- start while busy is ignored.

## Timing
- All state and outputs are registered except if_addr=pc and rf_addr=instr[4:0].
- Fetch latency is one FETCH cycle per wait cycle plus the ack cycle. An ack in the first FETCH cycle costs 1 cycle.
- Cycles per instruction with zero-wait fetch:
  - B or non-branch: 4 (FETCH, DECODE, EXEC, UPDATE).
  - CBZ or CBNZ: 5.
- retire and br_taken are high for exactly the UPDATE cycle. The pc register shows the new value in the following cycle, which is the first FETCH cycle.
- if_req deasserts in the cycle after the ack.
- An if_ack outside FETCH is ignored.

## Configuration
- BR_STATS_EN defined: adds two outputs, reset to 0, that saturate at 16'hFFFF.
  - br_taken_cnt, output, 16: increments on each br_taken pulse.
  - retire_cnt, output, 16: increments on each retire pulse.
- BR_STATS_EN undefined: neither port nor the counters exist; all other behaviour is identical.

## Test plan
- Reset with RESET_PC=0x100, then start, fetch non-branch 0x8B000000 with zero-wait ack -> pc=0x104 after 4 cycles, retire pulses once, br_taken=0.
- B with imm26=0x3FFFFFF (-1) at pc=0x100 -> pc=0x0FC, br_taken=1; B with imm26=0x2 -> pc=0x108.
- CBZ 0xB4000041 (imm19=2, Rt=1) with rf_data=0 -> pc+8, br_taken=1; rf_data=5 -> pc+4, br_taken=0; Rt=31 with rf_data=0xFFFF -> taken.
- CBNZ with rf_data=1 and imm19=0x7FFFF -> pc-4 taken; with pc=0 a negative offset wraps to 0xFFFFFFFFFFFFFFFC.
- Hold if_ack low 3 cycles -> if_req held 4 cycles; then fetch HALT_WORD -> halted=1, busy=0, pc frozen, start ignored.
- Assert reset_n low during READ -> next edge state IDLE, pc=RESET_PC, no retire. With BR_STATS_EN, 3 taken of 5 retired gives br_taken_cnt=3 and retire_cnt=5.

Source files
------------

// File: rtl/branch_seq_ctrl.sv
// Multicycle fetch/decode/execute sequencer for B, CBZ and CBNZ; owns the 64-bit PC.
// Optional BR_STATS_EN adds saturating br_taken_cnt / retire_cnt counters.
module branch_seq_ctrl #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] HALT_WORD = 32'hD4400000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        if_req,
  output logic [63:0] if_addr,
  input  logic        if_ack,
  input  logic [31:0] if_data,
  output logic [4:0]  rf_addr,
  input  logic [63:0] rf_data,
  output logic [63:0] pc,
  output logic        retire,
  output logic        br_taken,
  output logic        busy,
  output logic        halted
`ifdef BR_STATS_EN
  ,
  output logic [15:0] br_taken_cnt,
  output logic [15:0] retire_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, READ, EXEC, UPDATE, HALTED} state_t;
  typedef enum logic [1:0] {K_NONE, K_B, K_CBZ, K_CBNZ} kind_t;

  state_t      state;
  kind_t       kind;
  kind_t       dec_kind;
  logic [31:0] instr;
  logic [63:0] imm, dec_imm, opnd, next_pc, target;
  logic        take;

  assign if_addr = pc;
  assign rf_addr = instr[4:0];
  assign target  = pc + (imm << 2);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    dec_kind = K_NONE;
    dec_imm  = '0;
    if (instr[31:26] == 6'b000101) begin
      dec_kind = K_B;
      dec_imm  = {{38{instr[25]}}, instr[25:0]};
    end else if (instr[31:24] == 8'b10110100) begin
      dec_kind = K_CBZ;
      dec_imm  = {{45{instr[23]}}, instr[23:5]};
    end else if (instr[31:24] == 8'b10110101) begin
      dec_kind = K_CBNZ;
      dec_imm  = {{45{instr[23]}}, instr[23:5]};
    end
  end

  always_comb begin
    take = 1'b0;
    case (kind)
      K_B:     take = 1'b1;
      K_CBZ:   take = (opnd == 64'd0);
      K_CBNZ:  take = (opnd != 64'd0);
      default: take = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      instr    <= '0;
      opnd     <= '0;
      imm      <= '0;
      kind     <= K_NONE;
      next_pc  <= '0;
      if_req   <= 1'b0;
      retire   <= 1'b0;
      br_taken <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      retire   <= 1'b0;
      br_taken <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state  <= FETCH;
          if_req <= 1'b1;
          busy   <= 1'b1;
        end
        FETCH: if (if_ack) begin
          instr  <= if_data;
          if_req <= 1'b0;
          if (if_data == HALT_WORD) begin
            state  <= HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= DECODE;
          end
        end
        DECODE: begin
          kind  <= dec_kind;
          imm   <= dec_imm;
          state <= (dec_kind == K_CBZ || dec_kind == K_CBNZ) ? READ : EXEC;
        end
        READ: begin
          // Register 31 reads as XZR for the compare-and-branch forms.
          opnd  <= (instr[4:0] == 5'd31) ? 64'd0 : rf_data;
          state <= EXEC;
        end
        EXEC: begin
          next_pc  <= take ? target : pc + 64'd4;
          retire   <= 1'b1;
          br_taken <= take;
          state    <= UPDATE;
        end
        UPDATE: begin
          pc     <= next_pc;
          if_req <= 1'b1;
          state  <= FETCH;
        end
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BR_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_taken_cnt <= '0;
      retire_cnt   <= '0;
    end else begin
      if (br_taken && br_taken_cnt != 16'hFFFF) br_taken_cnt <= br_taken_cnt + 16'd1;
      if (retire && retire_cnt != 16'hFFFF)     retire_cnt   <= retire_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Table-driven bench for branch_seq_ctrl: instruction stream with hand-computed PCs,
// plus hand-written sequences for idle-ack, mid-instruction reset and halt.
module tb_branch_seq_ctrl;

  localparam logic [63:0] RPC  = 64'h100;
  localparam logic [31:0] HALT = 32'hD4400000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ack = 1'b0;
  logic [31:0] if_data = '0;
  logic [4:0]  rf_addr;
  logic [63:0] rf_data = '0;
  logic [63:0] pc;
  logic        retire, br_taken, busy, halted;
`ifdef BR_STATS_EN
  logic [15:0] br_taken_cnt, retire_cnt;
`endif

  branch_seq_ctrl #(.RESET_PC(RPC), .HALT_WORD(HALT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .rf_addr(rf_addr), .rf_data(rf_data), .pc(pc),
    .retire(retire), .br_taken(br_taken), .busy(busy), .halted(halted)
`ifdef BR_STATS_EN
    , .br_taken_cnt(br_taken_cnt), .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [63:0] rf;
    int          wt;
    logic [63:0] exp_pc;
    logic        exp_tk;
    int          exp_cyc;
  } vec_t;

  vec_t rows[15];

  initial begin
    int cyc, req_cyc, to, exp_taken_n;
    rows[0]  = '{32'h8B000000, 64'h0,    0, 64'h104, 1'b0, 4};
    rows[1]  = '{32'h17FFFFFF, 64'h0,    0, 64'h100, 1'b1, 4};
    rows[2]  = '{32'h17FFFFFF, 64'h0,    0, 64'h0FC, 1'b1, 4};
    rows[3]  = '{32'h14000002, 64'h0,    0, 64'h104, 1'b1, 4};
    rows[4]  = '{32'hB4000041, 64'h0,    0, 64'h10C, 1'b1, 5};
    rows[5]  = '{32'hB4000041, 64'h5,    0, 64'h110, 1'b0, 5};
    rows[6]  = '{32'hB400005F, 64'hFFFF, 0, 64'h118, 1'b1, 5};
    rows[7]  = '{32'hB5FFFFE1, 64'h1,    0, 64'h114, 1'b1, 5};
    rows[8]  = '{32'hB5FFFFE1, 64'h0,    0, 64'h118, 1'b0, 5};
    rows[9]  = '{32'h14000000, 64'h0,    0, 64'h118, 1'b1, 4};
    rows[10] = '{32'hB5FFFFFF, 64'h7,    0, 64'h11C, 1'b0, 5};
    rows[11] = '{32'h8B000000, 64'h0,    3, 64'h120, 1'b0, 4};
    rows[12] = '{32'h17FFFFB8, 64'h0,    0, 64'h0,   1'b1, 4};
    rows[13] = '{32'hB5FFFFE1, 64'h1,    0, 64'hFFFFFFFFFFFFFFFC, 1'b1, 5};
    rows[14] = '{32'h8B000000, 64'h0,    0, 64'h0,   1'b0, 4};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pc", pc, RPC);
    check("rst_if_req", if_req, 0);
    check("rst_retire", retire, 0);
    check("rst_br_taken", br_taken, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_rf_addr", rf_addr, 0);
    check("rst_if_addr", if_addr, RPC);
    reset_n = 1'b1;

    // Acknowledge while idle must be ignored.
    if_ack = 1'b1; if_data = HALT;
    repeat (2) @(negedge clk);
    check("idle_ack_halted", halted, 0);
    check("idle_ack_busy", busy, 0);
    check("idle_ack_req", if_req, 0);
    if_ack = 1'b0; if_data = '0;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);

    exp_taken_n = 0;
    for (int r = 0; r < 15; r++) begin
      rf_data = rows[r].rf;
      to = 0;
      while (!if_req && to < 20) begin @(negedge clk); to++; end
      check($sformatf("r%0d_fetch_addr", r), if_addr, pc);
      req_cyc = 0;
      for (int w = 0; w < rows[r].wt; w++) begin
        if (if_req) req_cyc++;
        @(negedge clk);
      end
      if (if_req) req_cyc++;
      check($sformatf("r%0d_req_cycles", r), req_cyc, rows[r].wt + 1);
      if_ack = 1'b1; if_data = rows[r].ins;
      cyc = 1;
      @(negedge clk);
      cyc++;
      if_ack = 1'b0; if_data = '0;
      check($sformatf("r%0d_req_drop", r), if_req, 0);
      while (!retire && cyc < 20) begin @(negedge clk); cyc++; end
      check($sformatf("r%0d_cycles", r), cyc, rows[r].exp_cyc);
      check($sformatf("r%0d_taken", r), br_taken, rows[r].exp_tk);
      @(negedge clk);
      check($sformatf("r%0d_pc", r), pc, rows[r].exp_pc);
      check($sformatf("r%0d_retire_once", r), retire, 0);
      if (rows[r].exp_tk) exp_taken_n++;
    end
`ifdef BR_STATS_EN
    check("stats_taken", br_taken_cnt, exp_taken_n);
    check("stats_retire", retire_cnt, 15);
`endif

    // Reset asserted during READ of a CBZ discards the instruction.
    rf_data = 64'h0;
    if_ack = 1'b1; if_data = 32'hB4000041;
    @(negedge clk);
    if_ack = 1'b0; if_data = '0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_pc", pc, RPC);
    check("midrst_busy", busy, 0);
    check("midrst_retire", retire, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("midrst_idle_busy", busy, 0);
      check("midrst_no_retire", retire, 0);
      check("midrst_pc_hold", pc, RPC);
    end

    // Halt: fetch HALT_WORD, then start is ignored and pc stays frozen.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if_ack = 1'b1; if_data = HALT;
    @(negedge clk);
    if_ack = 1'b0; if_data = '0;
    check("halt_halted", halted, 1);
    check("halt_busy", busy, 0);
    check("halt_req", if_req, 0);
    start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("halt_pc", pc, RPC);
      check("halt_no_retire", retire, 0);
      check("halt_stay", halted, 1);
      check("halt_no_req", if_req, 0);
    end
    start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
